mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_pkg.sv | 14 +
 rtl/mem_sat_counter.sv | 31 +++
 rtl/mem_access_ctrl.sv | 137 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and default widths for the memory access controller.
package mem_access_pkg;

    localparam int AW_DEFAULT = 16;
    localparam int DW_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/mem_sat_counter.sv
// Saturating event counter used for the optional load/store statistics.
module mem_sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding request/response bridge to a synchronous memory port.
// Optional load/store counters are enabled with MEM_ACCESS_CTRL_STATS_EN.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          memR,
    output logic          memW,
    output logic [AW-1:0] addr_out,
    output logic [DW-1:0] dataW_out,
    input  logic [DW-1:0] mem_in
`ifdef MEM_ACCESS_CTRL_STATS_EN
    ,
    output logic [DW-1:0] rd_count,
    output logic [DW-1:0] wr_count
`endif
);

    state_e        state_q,     state_d;
    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          mem_r_q,     mem_r_d;
    logic          mem_w_q,     mem_w_d;
    logic [AW-1:0] addr_q,      addr_d;
    logic [DW-1:0] wdata_q,     wdata_d;
    logic [DW-1:0] rdata_q,     rdata_d;
    logic          accept;

    assign accept = (state_q == IDLE) && req_valid && req_ready_q;

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        mem_r_d     = 1'b0;
        mem_w_d     = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        case (state_q)
            IDLE: begin
                // req_ready comes up one edge after reset release
                req_ready_d = 1'b1;
                if (accept) begin
                    state_d     = ISSUE;
                    req_ready_d = 1'b0;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    mem_r_d     = !req_we;
                    mem_w_d     = req_we;
                end
            end
            ISSUE: begin
                if (mem_r_q) begin
                    state_d = CAPT;
                end else begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                end
            end
            CAPT: begin
                state_d     = RESP;
                rdata_d     = mem_in;
                rsp_valid_d = 1'b1;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            mem_r_q     <= 1'b0;
            mem_w_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            mem_r_q     <= mem_r_d;
            mem_w_q     <= mem_w_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign memR      = mem_r_q;
    assign memW      = mem_w_q;
    assign addr_out  = addr_q;
    assign dataW_out = wdata_q;

`ifdef MEM_ACCESS_CTRL_STATS_EN
    mem_sat_counter #(.W(DW)) u_rd_cnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .inc   (accept && !req_we),
        .count (rd_count)
    );

    mem_sat_counter #(.W(DW)) u_wr_cnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .inc   (accept && req_we),
        .count (wr_count)
    );
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with a synchronous memory model.
module tb_mem_access_ctrl;

    logic        CLK;
    logic        RST_N;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        memR;
    logic        memW;
    logic [15:0] addr_out;
    logic [15:0] dataW_out;
    logic [15:0] mem_in;
`ifdef MEM_ACCESS_CTRL_STATS_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
`endif

    int checks   = 0;
    int failures = 0;
    int r_pulses = 0;
    int w_pulses = 0;
    int both_seen = 0;
    int r_base, w_base, both_base;

    logic [15:0] mem_arr [0:65535];

    mem_access_ctrl #(.AW(16), .DW(16)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .memR      (memR),
        .memW      (memW),
        .addr_out  (addr_out),
        .dataW_out (dataW_out),
        .mem_in    (mem_in)
`ifdef MEM_ACCESS_CTRL_STATS_EN
        ,
        .rd_count  (rd_count),
        .wr_count  (wr_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronous memory: read data appears the cycle after memR.
    always @(posedge CLK) begin
        if (memW) mem_arr[addr_out] <= dataW_out;
        if (memR) mem_in <= mem_arr[addr_out];
    end

    always @(negedge CLK) begin
        if (memR) r_pulses++;
        if (memW) w_pulses++;
        if (memR && memW) both_seen++;
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_store(input logic [15:0] a, input logic [15:0] d);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        rsp_ready = 1'b1;
        tick;
        req_valid = 1'b0;
        tick;
        tick;
    endtask

    initial begin
        RST_N = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = 16'h0; req_wdata = 16'h0; rsp_ready = 1'b0;
        mem_in = 16'h0;
        mem_arr[16'h0000] = 16'h1234;

        // reset state
        tick; tick;
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_memR", memR, 1'b0);
        chk("rst_memW", memW, 1'b0);
        chk("rst_addr_out", addr_out, 16'h0);
        chk("rst_dataW_out", dataW_out, 16'h0);
        chk("rst_rsp_rdata", rsp_rdata, 16'h0);
        RST_N = 1'b1;
        tick;
        chk("post_rst_req_ready", req_ready, 1'b1);
        $display("reset released, req_ready=%0b", req_ready);

        // store 0x0010 <- 0xBEEF
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0010; req_wdata = 16'hBEEF;
        rsp_ready = 1'b1;
        tick;
        chk("st_memW", memW, 1'b1);
        chk("st_memR", memR, 1'b0);
        chk("st_addr", addr_out, 16'h0010);
        chk("st_data", dataW_out, 16'hBEEF);
        chk("st_req_ready", req_ready, 1'b0);
        chk("st_rsp_valid_early", rsp_valid, 1'b0);
        req_valid = 1'b0; req_addr = 16'h5555; req_wdata = 16'h1111;
        tick;
        chk("st_rsp_valid", rsp_valid, 1'b1);
        chk("st_memW_one_cycle", memW, 1'b0);
        chk("st_addr_stable", addr_out, 16'h0010);
        chk("st_data_stable", dataW_out, 16'hBEEF);
        tick;
        chk("st_done_rsp_valid", rsp_valid, 1'b0);
        chk("st_done_req_ready", req_ready, 1'b1);
        $display("store addr=0x0010 data=0xBEEF complete");

        // load 0x0010, then stall response for 5 cycles
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010; req_wdata = 16'h0;
        tick;
        chk("ld_memR", memR, 1'b1);
        chk("ld_memW", memW, 1'b0);
        chk("ld_addr", addr_out, 16'h0010);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        tick;
        chk("ld_capt_rsp_valid", rsp_valid, 1'b0);
        chk("ld_memR_one_cycle", memR, 1'b0);
        tick;
        chk("ld_rsp_valid", rsp_valid, 1'b1);
        chk("ld_rdata", rsp_rdata, 16'hBEEF);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0777;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("stall_rsp_valid", rsp_valid, 1'b1);
            chk("stall_rdata", rsp_rdata, 16'hBEEF);
            chk("stall_req_ready", req_ready, 1'b0);
            chk("stall_mem_strobes", {memR, memW}, 2'b00);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick;
        chk("ld_done_rsp_valid", rsp_valid, 1'b0);
        chk("ld_done_req_ready", req_ready, 1'b1);
        chk("ld_done_rdata_held", rsp_rdata, 16'hBEEF);
        $display("load addr=0x0010 rdata=0x%h complete", rsp_rdata);

        // reset while in CAPT
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010;
        tick;
        req_valid = 1'b0;
        tick;
        chk("capt_rsp_valid", rsp_valid, 1'b0);
        #2 RST_N = 1'b0;
        #1;
        chk("midrst_req_ready", req_ready, 1'b0);
        chk("midrst_rsp_valid", rsp_valid, 1'b0);
        chk("midrst_strobes", {memR, memW}, 2'b00);
        chk("midrst_addr", addr_out, 16'h0);
        chk("midrst_data", dataW_out, 16'h0);
        chk("midrst_rdata", rsp_rdata, 16'h0);
        tick;
        chk("inrst_rsp_valid", rsp_valid, 1'b0);
        RST_N = 1'b1;
        tick;
        chk("rel_req_ready", req_ready, 1'b1);
        chk("rel_rsp_valid", rsp_valid, 1'b0);
        $display("reset during CAPT handled");

        // back-to-back store 0xFFFF then load 0x0000, req_valid held high
        r_base = r_pulses; w_base = w_pulses; both_base = both_seen;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'hFFFF; req_wdata = 16'hA5A5;
        rsp_ready = 1'b1;
        tick;
        chk("b2b_st_memW", memW, 1'b1);
        chk("b2b_st_addr", addr_out, 16'hFFFF);
        chk("b2b_st_data", dataW_out, 16'hA5A5);
        req_we = 1'b0; req_addr = 16'h0000; req_wdata = 16'h0;
        tick;
        chk("b2b_st_rsp", rsp_valid, 1'b1);
        tick;
        chk("b2b_idle_req_ready", req_ready, 1'b1);
        chk("b2b_idle_memR", memR, 1'b0);
        tick;
        chk("b2b_ld_memR", memR, 1'b1);
        chk("b2b_ld_addr", addr_out, 16'h0000);
        req_valid = 1'b0;
        tick;
        tick;
        chk("b2b_ld_rsp", rsp_valid, 1'b1);
        chk("b2b_ld_rdata", rsp_rdata, 16'h1234);
        chk("b2b_mem_ffff", mem_arr[16'hFFFF], 16'hA5A5);
        tick;
        chk("b2b_memR_pulses", r_pulses - r_base, 1);
        chk("b2b_memW_pulses", w_pulses - w_base, 1);
        chk("b2b_never_both", both_seen - both_base, 0);
        $display("back-to-back 0xFFFF store / 0x0000 load complete");

`ifdef MEM_ACCESS_CTRL_STATS_EN
        chk("stat_rd_before", rd_count, 16'd1);
        chk("stat_wr_before", wr_count, 16'd1);
        @(negedge CLK);
        dut.u_wr_cnt.count_q = 16'hFFFD;
        #1;
        do_store(16'h0020, 16'h0001);
        do_store(16'h0021, 16'h0002);
        do_store(16'h0022, 16'h0003);
        chk("stat_wr_sat", wr_count, 16'hFFFF);
        tick;
        chk("stat_wr_hold", wr_count, 16'hFFFF);
        chk("stat_rd_unaffected", rd_count, 16'd1);
        $display("stats wr_count=0x%h rd_count=0x%h", wr_count, rd_count);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
